// File: rtl/dma_utils_pkg.sv
// Shared AXI4-Lite bus types plus the DMA CSR register map, status layout and FSM states.
package dma_utils_pkg;

  typedef struct packed {
    logic [31:0] awaddr;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        rready;
  } s_axil_mosi_t;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
  } s_axil_miso_t;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  // Word offsets inside a 0x10-byte channel window.
  localparam logic [1:0] CH_REG_CTRL  = 2'd0;
  localparam logic [1:0] CH_REG_SRC   = 2'd1;
  localparam logic [1:0] CH_REG_DST   = 2'd2;
  localparam logic [1:0] CH_REG_BYTES = 2'd3;

  localparam logic [6:0] STATUS_WORD  = 7'h40;
  localparam logic [6:0] VERSION_WORD = 7'h41;

  localparam int CTRL_GO_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_BUSY_BIT   = 2;

  localparam int STATUS_DONE_LSB = 0;
  localparam int STATUS_ERR_LSB  = 16;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_dma_csr_mc_if.sv
// AXI4-Lite CSR bus bundle: request struct from the master, response struct from the slave.
interface axi_dma_csr_mc_if;
  import dma_utils_pkg::*;

  s_axil_mosi_t mosi;
  s_axil_miso_t miso;

  modport master (output mosi, input miso);
  modport slave  (input mosi, output miso);
endinterface

// File: rtl/dma_csr_ch.sv
// One DMA channel's CTRL/SRC/DST/BYTES registers, BUSY flag and GO pulse.
module dma_csr_ch
  import dma_utils_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_reg,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        done_pulse,
  input  logic        error_pulse,
  output logic        go,
  output logic        busy,
  output logic        irq_en,
  output logic [31:0] src,
  output logic [31:0] dst,
  output logic [31:0] bytes,
  output logic        wr_reject
);

  logic        go_reg, go_next;
  logic        busy_reg, busy_next;
  logic        irq_en_reg, irq_en_next;
  logic [31:0] src_reg, src_next;
  logic [31:0] dst_reg, dst_next;
  logic [31:0] bytes_reg, bytes_next;
  logic        go_req;

  assign go_req    = (wr_reg == CH_REG_CTRL) && wstrb[0] && wdata[CTRL_GO_BIT];
  // While busy only an IRQ_EN-only CTRL write is accepted cleanly.
  assign wr_reject = busy_reg && (go_req || (wr_reg != CH_REG_CTRL));

  always_comb begin
    go_next     = 1'b0;
    busy_next   = busy_reg;
    irq_en_next = irq_en_reg;
    src_next    = src_reg;
    dst_next    = dst_reg;
    bytes_next  = bytes_reg;
    if (done_pulse || error_pulse) busy_next = 1'b0;
    if (wr_en) begin
      case (wr_reg)
        CH_REG_CTRL: begin
          if (wstrb[0]) irq_en_next = wdata[CTRL_IRQ_EN_BIT];
          if (go_req && !busy_reg) begin
            go_next   = 1'b1;
            busy_next = 1'b1;
          end
        end
        CH_REG_SRC:   if (!busy_reg) src_next   = apply_wstrb(src_reg, wdata, wstrb);
        CH_REG_DST:   if (!busy_reg) dst_next   = apply_wstrb(dst_reg, wdata, wstrb);
        CH_REG_BYTES: if (!busy_reg) bytes_next = apply_wstrb(bytes_reg, wdata, wstrb);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      go_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      irq_en_reg <= 1'b0;
      src_reg    <= '0;
      dst_reg    <= '0;
      bytes_reg  <= '0;
    end else begin
      go_reg     <= go_next;
      busy_reg   <= busy_next;
      irq_en_reg <= irq_en_next;
      src_reg    <= src_next;
      dst_reg    <= dst_next;
      bytes_reg  <= bytes_next;
    end
  end

  assign go     = go_reg;
  assign busy   = busy_reg;
  assign irq_en = irq_en_reg;
  assign src    = src_reg;
  assign dst    = dst_reg;
  assign bytes  = bytes_reg;

endmodule

// File: rtl/axi_dma_csr_mc.sv
// Multi-channel DMA control/status register block on an AXI4-Lite slave port.
module axi_dma_csr_mc
  import dma_utils_pkg::*;
#(
  parameter int          N_CHANNELS = 4,
  parameter logic [31:0] VERSION_ID = 32'h0002_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  s_axil_mosi_t                 dma_csr_mosi_i,
  output s_axil_miso_t                 dma_csr_miso_o,
  output logic [N_CHANNELS-1:0]        ch_go_o,
  output logic [N_CHANNELS-1:0][31:0]  ch_src_o,
  output logic [N_CHANNELS-1:0][31:0]  ch_dst_o,
  output logic [N_CHANNELS-1:0][31:0]  ch_bytes_o,
  input  logic [N_CHANNELS-1:0]        ch_done_i,
  input  logic [N_CHANNELS-1:0]        ch_error_i,
  output logic                         dma_done_o,
  output logic                         dma_error_o
);

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  logic                  wr_hs, rd_hs;
  logic [1:0]            bresp_reg, bresp_next;
  logic [1:0]            rresp_reg, rd_resp;
  logic [31:0]           rdata_reg, rd_val;
  logic [6:0]            wr_word, rd_word;
  logic [N_CHANNELS-1:0] wr_ch_hit, ch_wr_en, ch_busy, ch_irq_en, ch_reject;
  logic                  wr_status, wr_mapped;
  logic [N_CHANNELS-1:0] done_reg, done_next, error_reg, error_next;
  logic [N_CHANNELS-1:0] done_clr, error_clr;
  logic                  unused_addr_bits;

  assign wr_word = dma_csr_mosi_i.awaddr[8:2];
  assign rd_word = dma_csr_mosi_i.araddr[8:2];
  assign unused_addr_bits = ^{dma_csr_mosi_i.awaddr[31:9], dma_csr_mosi_i.awaddr[1:0],
                              dma_csr_mosi_i.araddr[31:9], dma_csr_mosi_i.araddr[1:0]};

  // Write address decode and response selection.
  always_comb begin
    wr_ch_hit = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      wr_ch_hit[c] = !wr_word[6] && (wr_word[5:2] == 4'(c));
    end
    wr_status  = (wr_word == STATUS_WORD);
    wr_mapped  = (|wr_ch_hit) || wr_status || (wr_word == VERSION_WORD);
    bresp_next = (!wr_mapped || (|(wr_ch_hit & ch_reject))) ? AXI_SLVERR : AXI_OKAY;
  end

  assign ch_wr_en = wr_ch_hit & {N_CHANNELS{wr_hs}};

  always_comb begin
    w_state_next = w_state_reg;
    wr_hs        = 1'b0;
    case (w_state_reg)
      W_IDLE: if (dma_csr_mosi_i.awvalid && dma_csr_mosi_i.wvalid) begin
        wr_hs        = 1'b1;
        w_state_next = W_RESP;
      end
      W_RESP: if (dma_csr_mosi_i.bready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_next = r_state_reg;
    rd_hs        = 1'b0;
    case (r_state_reg)
      R_IDLE: if (dma_csr_mosi_i.arvalid) begin
        rd_hs        = 1'b1;
        r_state_next = R_DATA;
      end
      R_DATA: if (dma_csr_mosi_i.rready) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read mux sees registered state only, so a same-cycle write is not visible yet.
  always_comb begin
    rd_val  = '0;
    rd_resp = AXI_SLVERR;
    if (!rd_word[6]) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        if (rd_word[5:2] == 4'(c)) begin
          rd_resp = AXI_OKAY;
          case (rd_word[1:0])
            CH_REG_CTRL: begin
              rd_val[CTRL_IRQ_EN_BIT] = ch_irq_en[c];
              rd_val[CTRL_BUSY_BIT]   = ch_busy[c];
            end
            CH_REG_SRC:   rd_val = ch_src_o[c];
            CH_REG_DST:   rd_val = ch_dst_o[c];
            CH_REG_BYTES: rd_val = ch_bytes_o[c];
            default: ;
          endcase
        end
      end
    end else if (rd_word == STATUS_WORD) begin
      rd_resp = AXI_OKAY;
      rd_val[STATUS_DONE_LSB +: N_CHANNELS] = done_reg;
      rd_val[STATUS_ERR_LSB +: N_CHANNELS]  = error_reg;
    end else if (rd_word == VERSION_WORD) begin
      rd_resp = AXI_OKAY;
      rd_val  = VERSION_ID;
    end
  end

  // Sticky status: a completion pulse beats a W1C clear on the same bit.
  always_comb begin
    done_clr  = '0;
    error_clr = '0;
    if (wr_hs && wr_status && dma_csr_mosi_i.wstrb[0])
      done_clr = dma_csr_mosi_i.wdata[STATUS_DONE_LSB +: N_CHANNELS];
    if (wr_hs && wr_status && dma_csr_mosi_i.wstrb[2])
      error_clr = dma_csr_mosi_i.wdata[STATUS_ERR_LSB +: N_CHANNELS];
    done_next  = ch_done_i  | (done_reg  & ~done_clr);
    error_next = ch_error_i | (error_reg & ~error_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_reg <= W_IDLE;
      r_state_reg <= R_IDLE;
      bresp_reg   <= AXI_OKAY;
      rresp_reg   <= AXI_OKAY;
      rdata_reg   <= '0;
      done_reg    <= '0;
      error_reg   <= '0;
    end else begin
      w_state_reg <= w_state_next;
      r_state_reg <= r_state_next;
      if (wr_hs) bresp_reg <= bresp_next;
      if (rd_hs) begin
        rdata_reg <= rd_val;
        rresp_reg <= rd_resp;
      end
      done_reg  <= done_next;
      error_reg <= error_next;
    end
  end

  always_comb begin
    dma_csr_miso_o         = '0;
    dma_csr_miso_o.awready = wr_hs && !rst;
    dma_csr_miso_o.wready  = wr_hs && !rst;
    dma_csr_miso_o.bvalid  = (w_state_reg == W_RESP);
    dma_csr_miso_o.bresp   = bresp_reg;
    dma_csr_miso_o.arready = (r_state_reg == R_IDLE);
    dma_csr_miso_o.rvalid  = (r_state_reg == R_DATA);
    dma_csr_miso_o.rdata   = rdata_reg;
    dma_csr_miso_o.rresp   = rresp_reg;
  end

  assign dma_done_o  = |(done_reg  & ch_irq_en);
  assign dma_error_o = |(error_reg & ch_irq_en);

  for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_ch
    dma_csr_ch u_ch (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (ch_wr_en[gi]),
      .wr_reg     (wr_word[1:0]),
      .wdata      (dma_csr_mosi_i.wdata),
      .wstrb      (dma_csr_mosi_i.wstrb),
      .done_pulse (ch_done_i[gi]),
      .error_pulse(ch_error_i[gi]),
      .go         (ch_go_o[gi]),
      .busy       (ch_busy[gi]),
      .irq_en     (ch_irq_en[gi]),
      .src        (ch_src_o[gi]),
      .dst        (ch_dst_o[gi]),
      .bytes      (ch_bytes_o[gi]),
      .wr_reject  (ch_reject[gi])
    );
  end

endmodule

// File: tb/tb_axi_dma_csr_mc.sv
// Directed bench for the DMA CSR block: register access, GO/BUSY, sticky status, stalls and reset.
module tb_axi_dma_csr_mc;
  import dma_utils_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]       ch_go, ch_done, ch_error;
  logic [N-1:0][31:0] ch_src, ch_dst, ch_bytes;
  logic               dma_done, dma_error;

  axi_dma_csr_mc_if bus ();

  axi_dma_csr_mc #(.N_CHANNELS(N), .VERSION_ID(32'h0002_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .dma_csr_mosi_i(bus.mosi),
    .dma_csr_miso_o(bus.miso),
    .ch_go_o       (ch_go),
    .ch_src_o      (ch_src),
    .ch_dst_o      (ch_dst),
    .ch_bytes_o    (ch_bytes),
    .ch_done_i     (ch_done),
    .ch_error_i    (ch_error),
    .dma_done_o    (dma_done),
    .dma_error_o   (dma_error)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int go2_cnt  = 0;

  always @(negedge clk) if (ch_go[2]) go2_cnt <= go2_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input logic [N-1:0] dn, input logic [N-1:0] er,
                        output logic [1:0] resp, output logic [N-1:0] go_seen);
    bit ok;
    resp = 2'bxx;
    bus.mosi.awaddr  = addr;
    bus.mosi.wdata   = data;
    bus.mosi.wstrb   = strb;
    bus.mosi.awvalid = 1'b1;
    bus.mosi.wvalid  = 1'b1;
    bus.mosi.bready  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.miso.awready) begin ok = 1'b1; break; end
    end
    chk("aw_handshake", 32'(ok), 32'd1);
    ch_done  = dn;
    ch_error = er;
    @(posedge clk); #1;
    bus.mosi.awvalid = 1'b0;
    bus.mosi.wvalid  = 1'b0;
    ch_done  = '0;
    ch_error = '0;
    go_seen  = ch_go;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.miso.bvalid) begin resp = bus.miso.bresp; ok = 1'b1; break; end
    end
    chk("b_valid", 32'(ok), 32'd1);
    @(posedge clk); #1;
    $display("WR addr=%h data=%h strb=%b resp=%b", addr, data, strb, resp);
  endtask

  task automatic axi_rd(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ok;
    data = 'x;
    resp = 2'bxx;
    bus.mosi.araddr  = addr;
    bus.mosi.arvalid = 1'b1;
    bus.mosi.rready  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.miso.arready) begin ok = 1'b1; break; end
    end
    chk("ar_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.mosi.arvalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.miso.rvalid) begin data = bus.miso.rdata; resp = bus.miso.rresp; ok = 1'b1; break; end
    end
    chk("r_valid", 32'(ok), 32'd1);
    @(posedge clk); #1;
    $display("RD addr=%h data=%h resp=%b", addr, data, resp);
  endtask

  logic [1:0]   resp;
  logic [31:0]  rd;
  logic [N-1:0] gs;
  int           go_base;

  initial begin
    bus.mosi = '0;
    ch_done  = '0;
    ch_error = '0;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_awready", 32'(bus.miso.awready), 32'd0);
    chk("rst_wready",  32'(bus.miso.wready),  32'd0);
    chk("rst_bvalid",  32'(bus.miso.bvalid),  32'd0);
    chk("rst_rvalid",  32'(bus.miso.rvalid),  32'd0);
    chk("rst_arready", 32'(bus.miso.arready), 32'd1);
    chk("rst_go",      32'(ch_go),            32'd0);
    chk("rst_src1",    ch_src[1],             32'd0);
    chk("rst_irq",     32'({dma_done, dma_error}), 32'd0);

    axi_rd(32'h14, rd, resp);
    chk("rst_src1_rd", rd, 32'd0);

    // SRC write/readback and byte strobes on DST
    axi_wr(32'h14, 32'h8000_0000, 4'hF, '0, '0, resp, gs);
    chk("src1_bresp", 32'(resp), 32'(AXI_OKAY));
    axi_rd(32'h14, rd, resp);
    chk("src1_rdata", rd, 32'h8000_0000);
    chk("src1_rresp", 32'(resp), 32'(AXI_OKAY));
    chk("src1_port", ch_src[1], 32'h8000_0000);
    axi_wr(32'h18, 32'h1122_3344, 4'b0101, '0, '0, resp, gs);
    axi_rd(32'h18, rd, resp);
    chk("dst1_strb_rd", rd, 32'h0022_0044);
    chk("dst1_port", ch_dst[1], 32'h0022_0044);

    // GO on channel 2, then GO and SRC while busy
    go_base = go2_cnt;
    axi_wr(32'h20, 32'h3, 4'hF, '0, '0, resp, gs);
    chk("go2_bresp", 32'(resp), 32'(AXI_OKAY));
    chk("go2_pulse_cycle", 32'(gs), 32'h4);
    chk("go2_pulse_width", 32'(go2_cnt - go_base), 32'd1);
    axi_rd(32'h20, rd, resp);
    chk("ctrl2_busy", rd, 32'h6);
    axi_wr(32'h20, 32'h3, 4'hF, '0, '0, resp, gs);
    chk("go2_busy_bresp", 32'(resp), 32'(AXI_SLVERR));
    chk("go2_busy_nopulse", 32'(go2_cnt - go_base), 32'd1);
    axi_wr(32'h24, 32'hDEAD_BEEF, 4'hF, '0, '0, resp, gs);
    chk("src2_busy_bresp", 32'(resp), 32'(AXI_SLVERR));
    axi_rd(32'h24, rd, resp);
    chk("src2_busy_rd", rd, 32'd0);

    // Completion on channel 2 with IRQ enabled
    ch_done = 4'b0100;
    @(posedge clk); #1;
    ch_done = '0;
    @(negedge clk);
    chk("done_irq_set", 32'(dma_done), 32'd1);
    chk("error_irq_idle", 32'(dma_error), 32'd0);
    axi_rd(32'h100, rd, resp);
    chk("status_done2", rd, 32'h4);
    axi_rd(32'h20, rd, resp);
    chk("ctrl2_idle", rd, 32'h2);
    axi_wr(32'h100, 32'h4, 4'hF, '0, '0, resp, gs);
    @(negedge clk);
    chk("done_irq_clr", 32'(dma_done), 32'd0);
    axi_rd(32'h100, rd, resp);
    chk("status_clr", rd, 32'd0);

    // Error set alongside a W1C write; set wins on the same bit
    axi_wr(32'h100, 32'h4, 4'hF, '0, 4'b0001, resp, gs);
    axi_rd(32'h100, rd, resp);
    chk("status_err0", rd, 32'h0001_0000);
    chk("err_irq_masked", 32'(dma_error), 32'd0);
    axi_rd(32'h00, rd, resp);
    chk("ctrl0_not_busy", rd, 32'd0);
    axi_wr(32'h100, 32'h0001_0000, 4'b0100, '0, 4'b0001, resp, gs);
    axi_rd(32'h100, rd, resp);
    chk("status_set_wins", rd, 32'h0001_0000);
    axi_wr(32'h100, 32'h0001_0000, 4'b0011, '0, '0, resp, gs);
    axi_rd(32'h100, rd, resp);
    chk("status_strb_masked", rd, 32'h0001_0000);
    axi_wr(32'h100, 32'h0001_0000, 4'b0100, '0, '0, resp, gs);
    axi_rd(32'h100, rd, resp);
    chk("status_err_clr", rd, 32'd0);
    axi_wr(32'h00, 32'h2, 4'h1, '0, 4'b0001, resp, gs);
    @(negedge clk);
    chk("err_irq_set", 32'(dma_error), 32'd1);

    // Unmapped and read-only words
    axi_rd(32'h40, rd, resp);
    chk("rd40_rdata", rd, 32'd0);
    chk("rd40_rresp", 32'(resp), 32'(AXI_SLVERR));
    axi_rd(32'h108, rd, resp);
    chk("rd108_rdata", rd, 32'd0);
    chk("rd108_rresp", 32'(resp), 32'(AXI_SLVERR));
    axi_rd(32'h104, rd, resp);
    chk("version", rd, 32'h0002_0000);
    axi_wr(32'h40, 32'hFFFF_FFFF, 4'hF, '0, '0, resp, gs);
    chk("wr40_bresp", 32'(resp), 32'(AXI_SLVERR));
    axi_rd(32'h30, rd, resp);
    chk("ctrl3_rresp", 32'(resp), 32'(AXI_OKAY));

    // Stalled responses with fresh requests pending; read sees the pre-write value
    bus.mosi.awaddr  = 32'h0C;
    bus.mosi.wdata   = 32'h1000;
    bus.mosi.wstrb   = 4'hF;
    bus.mosi.awvalid = 1'b1;
    bus.mosi.wvalid  = 1'b1;
    bus.mosi.bready  = 1'b0;
    bus.mosi.araddr  = 32'h0C;
    bus.mosi.arvalid = 1'b1;
    bus.mosi.rready  = 1'b0;
    @(negedge clk);
    chk("stall_aw_hs", 32'(bus.miso.awready), 32'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      bus.mosi.awaddr = $urandom & 32'h1FC;
      bus.mosi.wdata  = $urandom;
      bus.mosi.araddr = $urandom & 32'h1FC;
      @(negedge clk);
      chk("stall_bvalid",  32'(bus.miso.bvalid),  32'd1);
      chk("stall_bresp",   32'(bus.miso.bresp),   32'(AXI_OKAY));
      chk("stall_awready", 32'(bus.miso.awready), 32'd0);
      chk("stall_rvalid",  32'(bus.miso.rvalid),  32'd1);
      chk("stall_rdata",   bus.miso.rdata,        32'd0);
      chk("stall_rresp",   32'(bus.miso.rresp),   32'(AXI_OKAY));
      chk("stall_arready", 32'(bus.miso.arready), 32'd0);
      @(posedge clk); #1;
    end
    bus.mosi.awvalid = 1'b0;
    bus.mosi.wvalid  = 1'b0;
    bus.mosi.arvalid = 1'b0;
    bus.mosi.bready  = 1'b1;
    bus.mosi.rready  = 1'b1;
    @(posedge clk); #1;
    chk("stall_b_done", 32'(bus.miso.bvalid), 32'd0);
    chk("stall_r_done", 32'(bus.miso.rvalid), 32'd0);
    axi_rd(32'h0C, rd, resp);
    chk("bytes0_after", rd, 32'h1000);

    // Reset while a read response is pending
    bus.mosi.araddr  = 32'h104;
    bus.mosi.arvalid = 1'b1;
    bus.mosi.rready  = 1'b0;
    @(posedge clk); #1;
    bus.mosi.arvalid = 1'b0;
    @(negedge clk);
    chk("pre_rst_rvalid", 32'(bus.miso.rvalid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_rvalid", 32'(bus.miso.rvalid), 32'd0);
    chk("mid_rst_arready", 32'(bus.miso.arready), 32'd1);
    rst = 1'b0;
    bus.mosi.rready = 1'b1;
    axi_rd(32'h14, rd, resp);
    chk("post_rst_src1", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_dma_csr_mc.md
AXI_DMA_CSR_MC -- requirements
Module: axi_dma_csr_mc

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 4, number of DMA channels (legal 1..8).
REQ-002 SHALL have parameter VERSION_ID, default 32'h0002_0000, value of the read-only VERSION register.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port dma_csr_mosi_i  input  s_axil_mosi_t  AXI4-Lite slave requests.
REQ-006 SHALL have port dma_csr_miso_o  output  s_axil_miso_t  AXI4-Lite slave responses.
REQ-007 SHALL have port ch_go_o  output  N_CHANNELS  one-cycle start pulse per channel.
REQ-008 SHALL have port ch_src_o  output  N_CHANNELS x 32  source address per channel.
REQ-009 SHALL have port ch_dst_o  output  N_CHANNELS x 32  destination address per channel.
REQ-010 SHALL have port ch_bytes_o  output  N_CHANNELS x 32  transfer length in bytes per channel.
REQ-011 SHALL have port ch_done_i  input  N_CHANNELS  one-cycle completion pulse per channel.
REQ-012 SHALL have port ch_error_i  input  N_CHANNELS  one-cycle error pulse per channel.
REQ-013 SHALL have port dma_done_o  output  1  level IRQ: OR of (done & irq_en).
REQ-014 SHALL have port dma_error_o  output  1  level IRQ: OR of (error & irq_en).

Function
REQ-015 Register map SHALL be: channel c at 0x10*c: +0x0 CTRL (bit0 GO W1, bit1 IRQ_EN RW, bit2 BUSY RO), +0x4 SRC, +0x8 DST, +0xC BYTES; 0x100 STATUS (done[N-1:0] at bits N-1:0, error at bits 16+N-1:16, W1C); 0x104 VERSION RO.
REQ-016 Address decode SHALL use awaddr/araddr[8:2]; any other word, or a channel index >= N_CHANNELS, is unmapped.
REQ-017 Write FSM SHALL have states W_IDLE and W_RESP; in W_IDLE awready and wready assert together only when awvalid and wvalid are both high; the handshake moves to W_RESP.
REQ-018 In W_RESP bvalid SHALL be high, with bresp held stable, until bready; then the FSM returns to W_IDLE; no new AW/W is accepted in W_RESP.
REQ-019 Read FSM SHALL have states R_IDLE (arready=1) and R_DATA; rvalid asserts the cycle after the AR handshake, with rdata/rresp held until rready.
REQ-020 Unmapped read or write SHALL return SLVERR (2'b10), with rdata 0 and no state change; all other accesses return OKAY.
REQ-021 SRC/DST/BYTES writes SHALL honour wstrb per byte; CTRL and STATUS writes SHALL use byte 0 and byte 2 only.
REQ-022 Writing GO=1 to an idle channel SHALL pulse ch_go_o[c] for exactly one cycle, the cycle after the write handshake, and set BUSY in the same cycle.
REQ-023 Writing GO=1, SRC, DST or BYTES while BUSY=1 SHALL be ignored and return SLVERR; IRQ_EN is still updated by the CTRL write.
REQ-024 ch_done_i[c] SHALL clear BUSY and set done[c]; ch_error_i[c] SHALL clear BUSY and set error[c]; both in the same cycle set both bits.
REQ-025 If a W1C clear and a set pulse hit the same STATUS bit in one cycle, set SHALL win.
REQ-026 ch_done_i/ch_error_i while BUSY=0 SHALL still set the sticky bits (no BUSY change).
REQ-027 ch_src_o/ch_dst_o/ch_bytes_o SHALL be registered copies of the CSRs; dma_done_o/dma_error_o SHALL be combinational from registered state.
REQ-028 The read and write FSMs SHALL be independent; a simultaneous read returns the pre-write value.

Reset
REQ-029 On rst, all CSRs, BUSY, done, error, ch_go_o, awready, wready, bvalid, rvalid SHALL be 0; arready SHALL be 1; FSMs SHALL go to W_IDLE/R_IDLE.
REQ-030 Reset mid-transaction SHALL drop bvalid/rvalid the next cycle; the outstanding response is lost.

Structure
REQ-031 Register offsets, the STATUS bit layout and the FSM state enums SHALL live in dma_utils_pkg alongside the existing s_axil_* types.
REQ-032 Per-channel CTRL/SRC/DST/BYTES/BUSY logic SHALL be a sub-module dma_csr_ch, instantiated N_CHANNELS times in a generate loop.

Verification
REQ-033 Write 0x8000_0000 to 0x14 and read 0x14 -> bresp OKAY; rdata 0x8000_0000; ch_src_o[1]=0x8000_0000.
REQ-034 Write 0x3 to 0x20 -> ch_go_o[2] high exactly one cycle; BUSY read 1; a second GO returns SLVERR with no pulse.
REQ-035 Pulse ch_done_i[2] with IRQ_EN=1 -> dma_done_o=1, STATUS reads 0x4; write 0x4 to 0x100 -> dma_done_o=0.
REQ-036 Write 0x4 to 0x100 in the same cycle as a ch_error_i[0] pulse -> error bit 16 remains set.
REQ-037 N_CHANNELS=4; read 0x40 and 0x108 -> rresp SLVERR, rdata 0; read 0x104 -> 0x0002_0000.
REQ-038 Hold bready/rready low for 5 cycles with random AW/W/AR stimulus -> bvalid/rvalid and data stable, no extra handshakes.
